idli_sqi_mem_m: RTL and testbench
=================================

# idli_sqi_mem_m

Synthesizable quad-SPI (SQI) SRAM responder modelling one external memory on the core's `mem_lo`/`mem_hi` port pair: it decodes READ/WRITE commands driven by the core, holds a byte-addressed storage array and returns read data nibble-by-nibble. The bench instantiates two of these, one per memory port, in place of the physical SRAMs. The same block can also be used on FPGA builds that have no external memory.

## Interface
- `ADDR_W`, default 16: storage address width in bits. Depth is 2^ADDR_W bytes. Address bits above ADDR_W-1 are ignored.
- `i_mem_gck`  in  1  core clock; all state updates on rising edge.
- `i_mem_rst_n`  in  1  asynchronous, active-low reset.
- `i_mem_sck`  in  1  SQI clock from core, treated as a transfer qualifier synchronous to `i_mem_gck`.
- `i_mem_cs`  in  1  chip select, active low.
- `i_mem_sio`  in  4  nibble driven by the core (`slice_t`).
- `o_mem_sio`  out  4  nibble driven to the core (`slice_t`).
- `o_mem_oe`  out  1  high while `o_mem_sio` carries read data. Used for bench checking only.

## Operation
- A transfer is a rising `i_mem_gck` edge with `i_mem_cs`=0 and `i_mem_sck`=1. No other edge changes protocol state.
- Nibble order is MSB first throughout.
- States:
  - IDLE:
    - Entered on reset, or whenever `i_mem_cs`=1 is sampled.
    - The first transfer goes to INSTR and counts as instruction nibble 0.
  - INSTR: after 2 nibbles, the 8-bit opcode is decoded:
    - 0x03 selects READ.
    - 0x02 selects WRITE.
    - Any other opcode goes to IGNORE.
  - ADDR:
    - 6 nibbles form a 24-bit address; the low ADDR_W bits are loaded into the address pointer.
    - Then READ goes to DUMMY and WRITE goes to DATA.
  - DUMMY (READ only):
    - 2 transfers; sampled input is discarded.
    - On the 2nd dummy transfer, `o_mem_sio` is loaded with mem[ptr][7:4] and `o_mem_oe` is set to 1.
  - DATA, READ:
    - A nibble toggle tracks the half of the current byte.
    - If the toggle is high, the transfer loads `o_mem_sio` with mem[ptr][3:0].
    - If the toggle is low, ptr increments and `o_mem_sio` is loaded with mem[ptr+1][7:4].
  - DATA, WRITE:
    - High-half transfers capture the nibble into a holding register.
    - Low-half transfers write mem[ptr] <= {held, i_mem_sio} and increment ptr.
  - IGNORE: all transfers are discarded; `o_mem_oe`=0; exits only when `i_mem_cs`=1.
- Sequential mode:
  - ptr wraps from 2^ADDR_W-1 to 0.
  - Bursts have unbounded length until `i_mem_cs` is deasserted.
- Deselect: `i_mem_cs`=1 sampled in any state gives:
  - next state IDLE
  - `o_mem_oe`=0
  - `o_mem_sio`=0
  - nibble toggle cleared
  - any half-written byte discarded, with memory unchanged.
- Storage array is never reset. Its content is undefined until written; the bench may preload it via hierarchical access.
- Read-after-write within the same chip-select window is not possible: READ and WRITE require separate commands.

## Timing
- Reset values: state IDLE, ptr 0, toggle 0, `o_mem_sio`=0, `o_mem_oe`=0.
- Outputs are registered. `o_mem_sio` is valid from the edge of the last dummy transfer, and each subsequent data transfer presents the next nibble.
- First read nibble:
  - Available 10 transfers after the first instruction nibble: 2 instruction + 6 address + 2 dummy.
  - The core samples it on the 11th transfer.
- Writes commit on the edge of the low-nibble transfer, and are visible to a later READ command.
- `i_mem_sck`=0 with `i_mem_cs`=0 stalls all state indefinitely; outputs hold.
- Reset asserted mid-command:
  - Immediate return to reset values.
  - Memory bytes already committed are retained.
  - No partial byte is written.
- Simultaneous `i_mem_cs` rising and `i_mem_sck`=1 on the same edge: the deselect wins and no transfer occurs.

## Test plan
- WRITE 0x02, addr 0x000010, data 0xA5 0x3C, deselect; then READ 0x03 at 0x000010 with 2 dummy transfers -> nibbles A,5,3,C on transfers 11-14, `o_mem_oe`=1 from the 10th transfer edge.
- WRITE at 0x00FFFF with ADDR_W=16, bytes 0x11 0x22 -> mem[0xFFFF]=0x11, mem[0x0000]=0x22. READ from 0x00FFFF returns 1,1,2,2.
- Opcode 0x05 followed by 12 transfers -> `o_mem_oe` stays 0, no memory change. The next command after deselect decodes normally.
- WRITE 0x02 at 0x20 with nibbles 7,8,9 then deselect -> mem[0x20]=0x78, mem[0x21] unchanged.
- READ burst with `i_mem_sck` held 0 for 5 cycles between nibbles -> `o_mem_sio` holds, and the sequence resumes without skipping a nibble.
- Assert `i_mem_rst_n`=0 mid-READ data phase -> `o_mem_oe`=0 and `o_mem_sio`=0 immediately. A later READ of previously written bytes returns the original values.

Source files
------------

// File: rtl/idli_sqi_mem_m_if.sv
// SQI memory bus between the core (master) and an SRAM responder (slave).
// The nibble fields correspond to the 4-bit slice_t used on the core side.
interface idli_sqi_mem_m_if;
   logic       i_mem_sck;
   logic       i_mem_cs;
   logic [3:0] i_mem_sio;
   logic [3:0] o_mem_sio;
   logic       o_mem_oe;

   modport master (
      output i_mem_sck, i_mem_cs, i_mem_sio,
      input  o_mem_sio, o_mem_oe
   );

   modport slave (
      input  i_mem_sck, i_mem_cs, i_mem_sio,
      output o_mem_sio, o_mem_oe
   );
endinterface

// File: rtl/idli_sqi_mem_m.sv
// Quad-SPI SRAM responder: decodes READ (0x03) / WRITE (0x02) commands,
// holds a byte-addressed array and streams read data MSB nibble first.
module idli_sqi_mem_m #(
   parameter int ADDR_W = 16
) (
   input  logic            i_mem_gck,
   input  logic            i_mem_rst_n,
   idli_sqi_mem_m_if.slave bus
);

   typedef logic [3:0] slice_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INSTR,
      ST_ADDR,
      ST_DUMMY,
      ST_DATA,
      ST_IGNORE
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [ADDR_W-1:0] rd_addr;
   logic [2:0]        cnt_q, cnt_d;
   slice_t            op_hi_q, op_hi_d;
   slice_t            hold_q, hold_d;
   slice_t            sio_q, sio_d;
   logic              rd_q, rd_d;
   logic              tog_q, tog_d;
   logic              oe_q, oe_d;
   logic              wr_en;
   logic [7:0]        wr_byte;
   logic [7:0]        rd_byte;

   // Storage is deliberately not reset so it survives a mid-command reset.
   logic [7:0] mem [2**ADDR_W];

   // In a read burst the low-half transfer already fetches the next byte.
   assign rd_addr = (state_q == ST_DATA && rd_q && !tog_q) ? ptr_q + ADDR_W'(1) : ptr_q;
   assign rd_byte = mem[rd_addr];

   assign bus.o_mem_sio = sio_q;
   assign bus.o_mem_oe  = oe_q;

   // Next-state and output computation; deselect overrides any transfer.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      op_hi_d = op_hi_q;
      hold_d  = hold_q;
      sio_d   = sio_q;
      rd_d    = rd_q;
      tog_d   = tog_q;
      oe_d    = oe_q;
      wr_en   = 1'b0;
      wr_byte = {hold_q, bus.i_mem_sio};
      if (bus.i_mem_cs) begin
         state_d = ST_IDLE;
         oe_d    = 1'b0;
         sio_d   = '0;
         tog_d   = 1'b0;
         cnt_d   = '0;
      end else if (bus.i_mem_sck) begin
         case (state_q)
            ST_IDLE: begin
               op_hi_d = bus.i_mem_sio;
               state_d = ST_INSTR;
            end
            ST_INSTR: begin
               cnt_d = '0;
               if ({op_hi_q, bus.i_mem_sio} == 8'h03) begin
                  rd_d    = 1'b1;
                  state_d = ST_ADDR;
               end else if ({op_hi_q, bus.i_mem_sio} == 8'h02) begin
                  rd_d    = 1'b0;
                  state_d = ST_ADDR;
               end else begin
                  state_d = ST_IGNORE;
               end
            end
            ST_ADDR: begin
               // Shifting through a pointer-width register keeps only the low address bits.
               ptr_d = {ptr_q[ADDR_W-5:0], bus.i_mem_sio};
               cnt_d = cnt_q + 3'd1;
               if (cnt_q == 3'd5) begin
                  cnt_d   = '0;
                  tog_d   = 1'b0;
                  state_d = rd_q ? ST_DUMMY : ST_DATA;
               end
            end
            ST_DUMMY: begin
               if (cnt_q == 3'd0) begin
                  cnt_d = 3'd1;
               end else begin
                  cnt_d   = '0;
                  sio_d   = rd_byte[7:4];
                  oe_d    = 1'b1;
                  tog_d   = 1'b1;
                  state_d = ST_DATA;
               end
            end
            ST_DATA: begin
               if (rd_q) begin
                  if (tog_q) begin
                     sio_d = rd_byte[3:0];
                     tog_d = 1'b0;
                  end else begin
                     ptr_d = ptr_q + ADDR_W'(1);
                     sio_d = rd_byte[7:4];
                     tog_d = 1'b1;
                  end
               end else begin
                  if (!tog_q) begin
                     hold_d = bus.i_mem_sio;
                     tog_d  = 1'b1;
                  end else begin
                     wr_en  = 1'b1;
                     ptr_d  = ptr_q + ADDR_W'(1);
                     tog_d  = 1'b0;
                  end
               end
            end
            ST_IGNORE: begin
               oe_d = 1'b0;
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Protocol state and registered outputs.
   always_ff @(posedge i_mem_gck or negedge i_mem_rst_n) begin
      if (!i_mem_rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         cnt_q   <= '0;
         op_hi_q <= '0;
         hold_q  <= '0;
         sio_q   <= '0;
         rd_q    <= 1'b0;
         tog_q   <= 1'b0;
         oe_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         op_hi_q <= op_hi_d;
         hold_q  <= hold_d;
         sio_q   <= sio_d;
         rd_q    <= rd_d;
         tog_q   <= tog_d;
         oe_q    <= oe_d;
      end
   end

   // Byte commit on the low-nibble write transfer.
   always_ff @(posedge i_mem_gck) begin
      if (wr_en) begin
         mem[ptr_q] <= wr_byte;
      end
   end

endmodule

// File: tb/tb_idli_sqi_mem_m.sv
// Self-checking bench for idli_sqi_mem_m: directed vector table, hand-written
// corner sequences and randomized commands against a byte-array model.
module tb_idli_sqi_mem_m;

   localparam int AW    = 16;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   idli_sqi_mem_m_if bus ();

   idli_sqi_mem_m #(.ADDR_W(AW)) dut (
      .i_mem_gck   (clk),
      .i_mem_rst_n (rst_n),
      .bus         (bus)
   );

   logic [7:0] model [DEPTH];
   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [23:0] addr;
      logic [7:0]  w0;
      logic [7:0]  w1;
      logic [7:0]  e0;
      logic [7:0]  e1;
   } vec_t;

   function automatic int idx(input logic [23:0] a, input int off);
      return (int'(a[AW-1:0]) + off) % DEPTH;
   endfunction

   task automatic check(input string nm, input logic [3:0] sio_e, input logic oe_e);
      total++;
      if (bus.o_mem_sio !== sio_e || bus.o_mem_oe !== oe_e) begin
         bad++;
         $display("FAIL %s: got sio=%h oe=%b, want sio=%h oe=%b", nm, bus.o_mem_sio, bus.o_mem_oe, sio_e, oe_e);
      end
   endtask

   task automatic check_byte(input string nm, input logic [7:0] got, input logic [7:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h, want %h", nm, got, want);
      end
   endtask

   task automatic xfer(input logic [3:0] n);
      bus.i_mem_cs  = 1'b0;
      bus.i_mem_sck = 1'b1;
      bus.i_mem_sio = n;
      @(posedge clk);
      #1;
      bus.i_mem_sck = 1'b0;
   endtask

   task automatic stall(input int n, input logic [3:0] sio_e, input logic oe_e);
      for (int k = 0; k < n; k++) begin
         bus.i_mem_cs  = 1'b0;
         bus.i_mem_sck = 1'b0;
         bus.i_mem_sio = 4'($urandom);
         @(posedge clk);
         #1;
         check("stall_hold", sio_e, oe_e);
      end
   endtask

   // sck stays high while cs rises so the deselect must win over a transfer.
   task automatic deselect();
      bus.i_mem_cs  = 1'b1;
      bus.i_mem_sck = 1'b1;
      bus.i_mem_sio = 4'($urandom);
      @(posedge clk);
      #1;
      check("deselect", 4'h0, 1'b0);
      bus.i_mem_sck = 1'b0;
   endtask

   task automatic send_hdr(input logic [7:0] op, input logic [23:0] a);
      logic [31:0] w;
      w = {op, a};
      for (int k = 0; k < 8; k++) begin
         xfer(w[31-4*k -: 4]);
         check("header", 4'h0, 1'b0);
      end
   endtask

   task automatic do_read(input logic [23:0] a, input int nbytes, input int stall_lo,
                          input int stall_hi, output logic [7:0] g0, output logic [7:0] g1);
      logic [7:0]  b;
      logic [3:0]  e;
      logic [15:0] cap;
      cap = '0;
      send_hdr(8'h03, a);
      xfer(4'($urandom));
      check("dummy1", 4'h0, 1'b0);
      for (int j = 0; j < 2 * nbytes; j++) begin
         xfer(4'($urandom));
         b = model[idx(a, j / 2)];
         e = (j % 2 == 1) ? b[3:0] : b[7:4];
         if (j < 4) cap = {cap[11:0], bus.o_mem_sio};
         check("read_nibble", e, 1'b1);
         if (stall_hi > 0) stall($urandom_range(stall_hi, stall_lo), e, 1'b1);
      end
      if (nbytes == 1) cap = {cap[7:0], 8'h00};
      g0 = cap[15:8];
      g1 = cap[7:0];
      deselect();
      $display("read  addr=%h bytes=%0d first=%h %h", a, nbytes, g0, g1);
   endtask

   task automatic do_write(input logic [23:0] a, input logic [7:0] d[4], input int n,
                           input bit extra, input logic [3:0] extra_nib);
      send_hdr(8'h02, a);
      for (int k = 0; k < n; k++) begin
         xfer(d[k][7:4]);
         check("write_hi", 4'h0, 1'b0);
         xfer(d[k][3:0]);
         check("write_lo", 4'h0, 1'b0);
         model[idx(a, k)] = d[k];
      end
      if (extra) begin
         xfer(extra_nib);
         check("write_partial", 4'h0, 1'b0);
      end
      deselect();
      $display("write addr=%h bytes=%0d partial=%0d", a, n, extra);
   endtask

   task automatic do_ignore(input logic [7:0] op, input int n);
      xfer(op[7:4]);
      check("ign_op", 4'h0, 1'b0);
      xfer(op[3:0]);
      check("ign_op", 4'h0, 1'b0);
      for (int k = 0; k < n; k++) begin
         xfer(4'($urandom));
         check("ignore", 4'h0, 1'b0);
      end
      deselect();
      $display("ignore op=%h transfers=%0d", op, n);
   endtask

   initial begin
      vec_t        tab [3];
      logic [7:0]  d [4];
      logic [7:0]  g0, g1, orig, op;
      logic [23:0] a;
      logic [15:0] lo;
      int          r, n;

      tab[0] = '{addr: 24'h000010, w0: 8'hA5, w1: 8'h3C, e0: 8'hA5, e1: 8'h3C};
      tab[1] = '{addr: 24'h00FFFF, w0: 8'h11, w1: 8'h22, e0: 8'h11, e1: 8'h22};
      tab[2] = '{addr: 24'hAB1234, w0: 8'h5A, w1: 8'hC3, e0: 8'h5A, e1: 8'hC3};

      for (int i = 0; i < DEPTH; i++) begin
         model[i]   = 8'($urandom);
         dut.mem[i] = model[i];
      end

      bus.i_mem_cs  = 1'b1;
      bus.i_mem_sck = 1'b0;
      bus.i_mem_sio = 4'h0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state", 4'h0, 1'b0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Directed write/readback vectors, including address wrap and ignored high bits.
      for (int i = 0; i < 3; i++) begin
         d[0] = tab[i].w0;
         d[1] = tab[i].w1;
         d[2] = 8'h00;
         d[3] = 8'h00;
         do_write(tab[i].addr, d, 2, 1'b0, 4'h0);
         do_read(tab[i].addr, 2, 0, 0, g0, g1);
         check_byte("vec_byte0", g0, tab[i].e0);
         check_byte("vec_byte1", g1, tab[i].e1);
      end
      do_read(24'h000000, 1, 0, 0, g0, g1);
      check_byte("wrap_addr0", g0, 8'h22);

      // Unknown opcode: no output, no memory change, next command decodes.
      do_ignore(8'h05, 12);
      do_read(24'h000010, 2, 0, 0, g0, g1);
      check_byte("after_ignore0", g0, 8'hA5);
      check_byte("after_ignore1", g1, 8'h3C);

      // Half-written byte is discarded on deselect.
      orig = model[16'h0021];
      d[0] = 8'h78;
      do_write(24'h000020, d, 1, 1'b1, 4'h9);
      do_read(24'h000020, 2, 0, 0, g0, g1);
      check_byte("partial_byte0", g0, 8'h78);
      check_byte("partial_byte1", g1, orig);

      // Five-cycle sck stall between every read nibble.
      do_read(24'h000010, 2, 5, 5, g0, g1);
      check_byte("stall_byte0", g0, 8'hA5);
      check_byte("stall_byte1", g1, 8'h3C);

      // Asynchronous reset during the read data phase.
      send_hdr(8'h03, 24'h000010);
      xfer(4'h0);
      xfer(4'h0);
      check("rst_pre_nib0", 4'hA, 1'b1);
      xfer(4'h0);
      check("rst_pre_nib1", 4'h5, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      check("rst_async", 4'h0, 1'b0);
      bus.i_mem_cs = 1'b1;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      $display("reset asserted mid-read");
      do_read(24'h000010, 2, 0, 0, g0, g1);
      check_byte("post_rst0", g0, 8'hA5);
      check_byte("post_rst1", g1, 8'h3C);

      // Randomized commands against the model.
      for (int it = 0; it < 40; it++) begin
         r  = $urandom_range(9, 0);
         lo = ($urandom_range(1, 0) == 1) ? 16'($urandom_range(63, 0)) : 16'(16'hFFF8 + $urandom_range(7, 0));
         a  = {8'($urandom), lo};
         n  = $urandom_range(4, 1);
         if (r < 4) begin
            for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
            do_write(a, d, n, 1'($urandom), 4'($urandom));
         end else if (r < 8) begin
            do_read(a, n, 0, 2, g0, g1);
         end else begin
            op = 8'($urandom);
            while (op == 8'h02 || op == 8'h03) op = 8'($urandom);
            do_ignore(op, $urandom_range(14, 1));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
